// File: rtl/vga_timing_pkg.sv
// ============================================================================
// Module   : vga_timing_pkg
// Brief    : Shared VGA raster constants, colour type and bar-pattern helpers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_timing_pkg;

    localparam int c_cnt_w    = 10;

    localparam int c_h_active = 640;
    localparam int c_h_fp     = 16;
    localparam int c_h_sync   = 96;
    localparam int c_h_bp     = 48;
    localparam int c_v_active = 480;
    localparam int c_v_fp     = 10;
    localparam int c_v_sync   = 2;
    localparam int c_v_bp     = 33;
    localparam bit c_sync_pol = 1'b0;

    typedef logic [11:0] rgb_t;

    localparam rgb_t c_white   = 12'hFFF;
    localparam rgb_t c_yellow  = 12'hFF0;
    localparam rgb_t c_cyan    = 12'h0FF;
    localparam rgb_t c_green   = 12'h0F0;
    localparam rgb_t c_magenta = 12'hF0F;
    localparam rgb_t c_red     = 12'hF00;
    localparam rgb_t c_blue    = 12'h00F;
    localparam rgb_t c_black   = 12'h000;

    function automatic int axis_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int h_total_of(input int active, input int fp,
                                      input int sync, input int bp);
        return axis_total(active, fp, sync, bp);
    endfunction

    function automatic int v_total_of(input int active, input int fp,
                                      input int sync, input int bp);
        return axis_total(active, fp, sync, bp);
    endfunction

    // Threshold search avoids a divider for non-power-of-two bar widths.
    function automatic logic [2:0] bar_index(input logic [c_cnt_w-1:0] xv,
                                             input int bar_w);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (int'(xv) >= i * bar_w) idx = 3'(i);
        end
        return idx;
    endfunction

    function automatic rgb_t bar_color(input logic [2:0] idx);
        rgb_t c;
        case (idx)
            3'd0:    c = c_white;
            3'd1:    c = c_yellow;
            3'd2:    c = c_cyan;
            3'd3:    c = c_green;
            3'd4:    c = c_magenta;
            3'd5:    c = c_red;
            3'd6:    c = c_blue;
            default: c = c_black;
        endcase
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vga_axis_timing.sv
// ============================================================================
// Module   : vga_axis_timing
// Brief    : One raster axis counter; active/sync flags decode the next count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_axis_timing
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               adv,
    output logic [c_cnt_w-1:0] count,
    output logic               wrap,
    output logic               active,
    output logic               sync
);

    localparam int                 c_total = axis_total(ACTIVE, FP, SYNC, BP);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(c_total - 1);

    generate
        if (c_total > (1 << c_cnt_w)) begin : g_range_chk
            $error("vga_axis_timing: axis total does not fit the counter width");
        end
    endgenerate

    logic [c_cnt_w-1:0] w_count_nxt;

    // wrap means the count becomes 0 on the coming edge.
    always_comb begin
        wrap        = 1'b0;
        w_count_nxt = count;
        if (rst) begin
            w_count_nxt = c_last;
        end else if (adv) begin
            if (count == c_last) begin
                wrap        = 1'b1;
                w_count_nxt = '0;
            end else begin
                w_count_nxt = count + 1'b1;
            end
        end
        active = int'(w_count_nxt) < ACTIVE;
        sync   = (int'(w_count_nxt) >= ACTIVE + FP) &&
                 (int'(w_count_nxt) <  ACTIVE + FP + SYNC);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= c_last;
        end else begin
            count <= w_count_nxt;
        end
    end

endmodule

`default_nettype wire

// File: rtl/vga_sync_gen.sv
// ============================================================================
// Module   : vga_sync_gen
// Brief    : 640x480@60 raster timing; VGA_TEST_PATTERN_EN adds a colour-bar rgb.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = c_h_active,
    parameter int H_FP     = c_h_fp,
    parameter int H_SYNC   = c_h_sync,
    parameter int H_BP     = c_h_bp,
    parameter int V_ACTIVE = c_v_active,
    parameter int V_FP     = c_v_fp,
    parameter int V_SYNC   = c_v_sync,
    parameter int V_BP     = c_v_bp,
    parameter bit SYNC_POL = c_sync_pol
)(
    input  logic               pixel_clk,
    input  logic               reset,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic [c_cnt_w-1:0] x,
    output logic [c_cnt_w-1:0] y,
    output logic               line_start,
    output logic               frame_start
`ifdef VGA_TEST_PATTERN_EN
    ,
    output rgb_t               rgb
`endif
);

    logic w_h_wrap, w_h_active, w_h_sync;
    logic w_v_wrap, w_v_active, w_v_sync;

    vga_axis_timing #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_axis (
        .clk    (pixel_clk),
        .rst    (reset),
        .adv    (1'b1),
        .count  (x),
        .wrap   (w_h_wrap),
        .active (w_h_active),
        .sync   (w_h_sync)
    );

    vga_axis_timing #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_axis (
        .clk    (pixel_clk),
        .rst    (reset),
        .adv    (w_h_wrap),
        .count  (y),
        .wrap   (w_v_wrap),
        .active (w_v_active),
        .sync   (w_v_sync)
    );

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            video_on    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hsync       <= w_h_sync ? SYNC_POL : ~SYNC_POL;
            vsync       <= w_v_sync ? SYNC_POL : ~SYNC_POL;
            video_on    <= w_h_active & w_v_active;
            line_start  <= w_h_wrap;
            frame_start <= w_h_wrap & w_v_wrap;
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    localparam int c_bar_w = H_ACTIVE / 8;

    logic [c_cnt_w-1:0] w_x_nxt;

    assign w_x_nxt = w_h_wrap ? '0 : x + 1'b1;

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            rgb <= c_black;
        end else if (w_h_active && w_v_active) begin
            rgb <= bar_color(bar_index(w_x_nxt, c_bar_w));
        end else begin
            rgb <= c_black;
        end
    end
`endif

endmodule

`default_nettype wire

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Raster timing generator that consumes the 25 MHz pixel_clk produced by the clock divider stage.
- Produces hsync and vsync, an active-video flag, the current pixel coordinates, and frame and line strobes for 640x480@60 VGA.
- Drives the pixel/colour logic downstream and the VGA connector pins.
- Timing values are parameterised; defaults are the industry 640x480 mode.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, sync active level (0 = active-low, 1 = active-high)

Ports:
- pixel_clk  in  1  pixel clock, 25 MHz from clock divider; sole clock
- reset  in  1  synchronous, active-high reset
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- video_on  out  1  high when (x,y) is in the visible region
- x  out  10  horizontal counter, 0..H_TOTAL-1
- y  out  10  vertical counter, 0..V_TOTAL-1
- line_start  out  1  one-cycle pulse when x==0
- frame_start  out  1  one-cycle pulse when x==0 and y==0

Behaviour:
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800).
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
  - Both must fit in 10 bits; elaboration error otherwise.
- Single clock domain: pixel_clk. Every output is a register updated on the pixel_clk rising edge.
- Counter update each cycle:
  - If x==H_TOTAL-1: x wraps to 0 and y advances.
  - Otherwise x increments by 1.
  - When y advances from V_TOTAL-1, it wraps to 0.
  - y changes only on the x wrap cycle.
- Output timing:
  - Outputs are decoded from the next-state counter values, so every output is aligned with the x/y it accompanies. There is zero cycle skew between coordinates and flags.
  - video_on = (x < H_ACTIVE) && (y < V_ACTIVE).
  - hsync is active (==SYNC_POL) for H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC (default 656..751).
  - vsync is active for V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (default 490..491). vsync is independent of x.
  - line_start = (x==0); frame_start = (x==0 && y==0).
- Reset:
  - While reset is high: x=H_TOTAL-1, y=V_TOTAL-1, video_on=0, hsync=vsync=!SYNC_POL, line_start=0, frame_start=0.
  - The first rising edge with reset low yields x=0, y=0, video_on=1, line_start=1, frame_start=1.
  - Reset asserted mid-frame takes effect on the next edge, with no partial-line completion.
- Periodicity:
  - line_start period is exactly H_TOTAL cycles.
  - frame_start period is exactly H_TOTAL*V_TOTAL cycles (420000).
  - The block has no stall and no handshake; it free-runs.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- Defined:
  - Adds output port rgb, out, 12 bits (4:4:4), registered and aligned with x/y.
  - Shows 8 vertical colour bars, each H_ACTIVE/8 px wide.
  - Bar index b = x/(H_ACTIVE/8), giving the sequence white, yellow, cyan, green, magenta, red, blue, black. Each channel is 4'hF or 4'h0.
  - rgb = 12'h000 whenever video_on==0, and also during reset.
- Undefined: the rgb port and all its logic are absent.

Decomposition:
- Package vga_timing_pkg holds:
  - the default timing constants, and H_TOTAL/V_TOTAL derivation functions;
  - the counter width constant (10);
  - the 12-bit colour type and the 8 bar colour constants.
- One natural sub-module, vga_axis_timing, instantiated twice (horizontal and vertical):
  - inputs: advance enable and reset;
  - parameters: ACTIVE, FP, SYNC, BP;
  - outputs: count, wrap flag, active flag, sync flag.

Test Plan:
- Reset for 3 cycles, then release:
  - during reset, video_on=0, hsync=vsync=1, x=799, y=524;
  - first edge after release gives x=0, y=0, frame_start=1, video_on=1.
- Run one line:
  - video_on falls at x=640;
  - hsync low for exactly 96 cycles, x=656..751;
  - x wraps 799->0 with y 0->1 and line_start=1;
  - 800 cycles between line_start pulses.
- Run full frame:
  - vsync low only for y=490..491 (1600 cycles);
  - next frame_start exactly 420000 cycles after the first;
  - y wraps 524->0.
- Reset asserted at x=300, y=200:
  - next edge x=799, y=524, outputs inactive;
  - release gives frame_start on the first edge.
- SYNC_POL=1 instance: hsync high only for x=656..751, vsync high only for y=490..491, idle low during reset.
- With VGA_TEST_PATTERN_EN:
  - x=0 gives rgb=12'hFFF; x=80 gives 12'hFF0; x=639 gives 12'h000;
  - x=700 (blanking) gives 12'h000;
  - y=479/x=100 gives 12'hFF0.
